spi_slave_phy: RTL and testbench

// - SPI slave physical layer: mode 0 (CPOL=0, CPHA=0), MSB first, fixed WIDTH-bit words.
// - Synchronises pad SCK/MOSI/CSN into i_clk; deserialises MOSI and serialises MISO.
// - Feeds the SPI regbank front-end: o_rx_data/o_rx_valid/o_txe/o_csn drive its data/rx/txe/csn inputs.
// - Its data/valid-tx outputs drive i_tx_data/i_tx_valid here.

---
 rtl/spi_pkg.sv | 22 ++
 rtl/spi_sync_edge.sv | 64 ++++++
 rtl/spi_slave_phy.sv | 275 +++++++++++++++++++++++++++
 tb/tb_spi_slave_phy.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pkg
//  Description : Shared constants and types for the SPI slave physical layer.
//                SPI_WORD_W  - default word length in bits
//                SPI_TX_IDLE - default word shifted out when the TX buffer is
//                              empty at a word boundary
//                spi_phy_state_t - frame state (IDLE / ACTIVE)
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    localparam int                    SPI_WORD_W  = 16;
    localparam logic [SPI_WORD_W-1:0] SPI_TX_IDLE = 16'h0000;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_phy_state_t;

endpackage : spi_pkg
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : spi_sync_edge
//  Description : STAGES-flop synchroniser for one asynchronous pad input, with
//                optional single-cycle rise/fall strobes.
//  Ports       : i_clk    - sampling clock
//                i_rst_n  - synchronous active-low reset
//                i_async  - asynchronous pad input
//                o_sync   - synchronised level (last synchroniser stage)
//                o_rise   - 1-cycle strobe on a synchronised 0->1 (EDGES=1)
//                o_fall   - 1-cycle strobe on a synchronised 1->0 (EDGES=1)
//  Parameters  : STAGES (>=2), EDGES (strobes present), RST_VAL (reset level)
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_sync_edge #(
    parameter int STAGES  = 2,
    parameter bit EDGES   = 1'b1,
    parameter bit RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync <= {STAGES{RST_VAL}};
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_sync[STAGES-1];

    generate
        if (EDGES) begin : g_edges
            // Edge history flop: the strobe fires in the same cycle the new
            // level appears on o_sync, so plain-synchronised companion inputs
            // (same STAGES) are sampled with identical age.
            logic r_prev;

            always_ff @(posedge i_clk) begin
                if (!i_rst_n) begin
                    r_prev <= RST_VAL;
                end else begin
                    r_prev <= r_sync[STAGES-1];
                end
            end

            assign o_rise =  r_sync[STAGES-1] & ~r_prev;
            assign o_fall = ~r_sync[STAGES-1] &  r_prev;
        end else begin : g_no_edges
            assign o_rise = 1'b0;
            assign o_fall = 1'b0;
        end
    endgenerate

endmodule : spi_sync_edge
`default_nettype wire

// File: rtl/spi_slave_phy.sv
`default_nettype none
// ============================================================================
//  Module      : spi_slave_phy
//  Description : SPI slave physical layer, mode 0 (CPOL=0, CPHA=0), MSB first,
//                fixed WIDTH-bit words. Pads are synchronised into i_clk
//                (i_clk must be >= 4x SCK). RX words are presented with a
//                1-cycle valid pulse; TX words come from a single-entry buffer.
//  Ports       : i_clk, i_rst_n       - clock, synchronous active-low reset
//                i_sck, i_mosi        - SPI clock / data-in pads (async)
//                i_csn_pad            - SPI chip select pad, active-low
//                o_miso, o_miso_oe    - SPI data out and its output enable
//                o_rx_data/o_rx_valid - received word and update pulse
//                i_tx_data/i_tx_valid - TX buffer write
//                o_txe                - TX buffer empty
//                o_csn                - synchronised chip select
//                o_err_ovr, o_err_udr, i_err_clr - sticky error flags
//                                       (only with SPI_PHY_ERR_FLAGS_EN)
//  Config      : `define SPI_PHY_ERR_FLAGS_EN adds the error flag ports.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_phy
    import spi_pkg::*;
#(
    parameter int               WIDTH       = SPI_WORD_W,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] TX_IDLE     = WIDTH'(SPI_TX_IDLE)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_sck,
    input  logic             i_mosi,
    input  logic             i_csn_pad,
    output logic             o_miso,
    output logic             o_miso_oe,
    output logic [WIDTH-1:0] o_rx_data,
    output logic             o_rx_valid,
    input  logic [WIDTH-1:0] i_tx_data,
    input  logic             i_tx_valid,
    output logic             o_txe,
`ifdef SPI_PHY_ERR_FLAGS_EN
    output logic             o_err_ovr,
    output logic             o_err_udr,
    input  logic             i_err_clr,
`endif
    output logic             o_csn
);

    localparam int              CNT_W      = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(WIDTH - 1);

    // ------------------------------------------------------------------
    // Pad synchronisers
    // ------------------------------------------------------------------
    logic w_sck_rise;
    logic w_sck_fall;
    logic w_sck_sync_unused;
    logic w_mosi_sync;
    logic w_mosi_rise_unused;
    logic w_mosi_fall_unused;
    logic w_csn_sync;
    logic w_csn_rise_unused;
    logic w_csn_fall_unused;

    spi_sync_edge #(
        .STAGES  (SYNC_STAGES),
        .EDGES   (1'b1),
        .RST_VAL (1'b0)
    ) u_sync_sck (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_async (i_sck),
        .o_sync  (w_sck_sync_unused),
        .o_rise  (w_sck_rise),
        .o_fall  (w_sck_fall)
    );

    spi_sync_edge #(
        .STAGES  (SYNC_STAGES),
        .EDGES   (1'b0),
        .RST_VAL (1'b0)
    ) u_sync_mosi (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_async (i_mosi),
        .o_sync  (w_mosi_sync),
        .o_rise  (w_mosi_rise_unused),
        .o_fall  (w_mosi_fall_unused)
    );

    spi_sync_edge #(
        .STAGES  (SYNC_STAGES),
        .EDGES   (1'b0),
        .RST_VAL (1'b1)
    ) u_sync_csn (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_async (i_csn_pad),
        .o_sync  (w_csn_sync),
        .o_rise  (w_csn_rise_unused),
        .o_fall  (w_csn_fall_unused)
    );

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    spi_phy_state_t   r_state;
    spi_phy_state_t   w_state_nxt;

    logic [CNT_W-1:0] r_bit_cnt;
    logic             r_wrapped;     // last SCK rise completed a word
    logic             r_word_done;   // one-cycle delayed publish of the word
    logic [WIDTH-1:0] r_rx_shift;
    logic [WIDTH-1:0] r_rx_data;
    logic             r_rx_valid;
    logic [WIDTH-1:0] r_tx_shift;
    logic [WIDTH-1:0] r_tx_buf;
    logic             r_tx_full;

    logic             w_active;
    logic             w_frame_start;
    logic             w_boundary_load;
    logic             w_load;
    logic [WIDTH-1:0] w_load_word;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and load decisions
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_frame_start   = 1'b0;
        w_active        = 1'b0;
        w_boundary_load = 1'b0;
        w_load          = 1'b0;
        w_load_word     = r_tx_full ? r_tx_buf : TX_IDLE;

        case (r_state)
            IDLE: begin
                if (!w_csn_sync) begin
                    w_state_nxt   = ACTIVE;
                    w_frame_start = 1'b1;
                end
            end
            ACTIVE: begin
                if (w_csn_sync) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_active = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // The first fall after a word-completing rise reloads instead of shifting.
        w_boundary_load = w_active & w_sck_fall & r_wrapped;
        w_load          = w_frame_start | w_boundary_load;
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_bit_cnt   <= '0;
            r_wrapped   <= 1'b0;
            r_word_done <= 1'b0;
            r_rx_shift  <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_tx_shift  <= '0;
            r_tx_buf    <= '0;
            r_tx_full   <= 1'b0;
        end else begin
            r_word_done <= 1'b0;
            r_rx_valid  <= r_word_done;
            if (r_word_done) begin
                r_rx_data <= r_rx_shift;
            end

            // Receive side. Leaving the frame discards any partial word by
            // rewinding the counter; the shift register itself is refilled
            // completely before it is published again, so it is not cleared
            // (clearing could corrupt a word whose publish is one cycle away).
            if (!w_active) begin
                r_bit_cnt <= '0;
                r_wrapped <= 1'b0;
            end else if (w_sck_rise) begin
                r_rx_shift <= {r_rx_shift[WIDTH-2:0], w_mosi_sync};
                if (r_bit_cnt == C_LAST_BIT) begin
                    r_bit_cnt   <= '0;
                    r_word_done <= 1'b1;
                    r_wrapped   <= 1'b1;
                end else begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
            end else if (w_sck_fall) begin
                r_wrapped <= 1'b0;
            end

            // Transmit shift register
            if (w_load) begin
                r_tx_shift <= w_load_word;
            end else if (w_active && w_sck_fall) begin
                r_tx_shift <= {r_tx_shift[WIDTH-2:0], 1'b0};
            end

            // Single-entry TX buffer: a write in the same cycle as a load
            // keeps the new word while the load takes the old one.
            if (i_tx_valid) begin
                r_tx_buf  <= i_tx_data;
                r_tx_full <= 1'b1;
            end else if (w_load) begin
                r_tx_full <= 1'b0;
            end
        end
    end

`ifdef SPI_PHY_ERR_FLAGS_EN
    // ------------------------------------------------------------------
    // Sticky error flags (set wins over clear)
    // ------------------------------------------------------------------
    logic r_err_ovr;
    logic r_err_udr;
    logic w_ovr_set;
    logic w_udr_set;

    assign w_ovr_set = i_tx_valid & r_tx_full & ~w_load;
    assign w_udr_set = w_boundary_load & ~r_tx_full;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_err_ovr <= 1'b0;
            r_err_udr <= 1'b0;
        end else begin
            if (w_ovr_set) begin
                r_err_ovr <= 1'b1;
            end else if (i_err_clr) begin
                r_err_ovr <= 1'b0;
            end
            if (w_udr_set) begin
                r_err_udr <= 1'b1;
            end else if (i_err_clr) begin
                r_err_udr <= 1'b0;
            end
        end
    end

    assign o_err_ovr = r_err_ovr;
    assign o_err_udr = r_err_udr;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_miso     = (r_state == ACTIVE) & r_tx_shift[WIDTH-1];
    assign o_miso_oe  = ~w_csn_sync;
    assign o_csn      = w_csn_sync;
    assign o_rx_data  = r_rx_data;
    assign o_rx_valid = r_rx_valid;
    assign o_txe      = ~r_tx_full;

endmodule : spi_slave_phy
`default_nettype wire

// File: tb/tb_spi_slave_phy.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_slave_phy
//  Description : Self-checking bench for spi_slave_phy. A mode-0 SPI master
//                drives the pads at SCK = clk/8; received words go through a
//                scoreboard queue popped by an independent monitor, MISO words
//                are compared with a transaction-level TX buffer model.
//                Honours SPI_PHY_ERR_FLAGS_EN for the optional flag ports.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave_phy;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sck;
    logic        mosi;
    logic        csn;
    logic        miso;
    logic        miso_oe;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        txe;
    logic        csn_sync;
`ifdef SPI_PHY_ERR_FLAGS_EN
    logic        err_ovr;
    logic        err_udr;
    logic        err_clr;
`endif

    always #5 clk = ~clk;

    spi_slave_phy dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_sck      (sck),
        .i_mosi     (mosi),
        .i_csn_pad  (csn),
        .o_miso     (miso),
        .o_miso_oe  (miso_oe),
        .o_rx_data  (rx_data),
        .o_rx_valid (rx_valid),
        .i_tx_data  (tx_data),
        .i_tx_valid (tx_valid),
        .o_txe      (txe),
`ifdef SPI_PHY_ERR_FLAGS_EN
        .o_err_ovr  (err_ovr),
        .o_err_udr  (err_udr),
        .i_err_clr  (err_clr),
`endif
        .o_csn      (csn_sync)
    );

    int checks = 0;
    int errors = 0;

    // Scoreboard of words the master has fully clocked in
    logic [15:0] rx_q[$];

    // Transaction-level TX model
    logic [15:0] m_buf  = 16'h0;
    logic        m_full = 1'b0;
    logic        m_ovr  = 1'b0;
    logic        m_udr  = 1'b0;
    logic [15:0] m_cur  = 16'h0;

    // Frame description
    logic [15:0] fw [4];
    int          fwr_at [4];
    logic [15:0] fwd [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] consume(input logic boundary);
        logic [15:0] w;
        if (m_full) begin
            w      = m_buf;
            m_full = 1'b0;
        end else begin
            w = 16'h0000;
            if (boundary) m_udr = 1'b1;
        end
        return w;
    endfunction

    task automatic tx_write(input logic [15:0] d);
        @(posedge clk); #1;
        tx_data  = d;
        tx_valid = 1'b1;
        if (m_full) m_ovr = 1'b1;
        m_buf  = d;
        m_full = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
    endtask

    task automatic check_flags();
`ifdef SPI_PHY_ERR_FLAGS_EN
        chk("err_ovr", {31'd0, err_ovr}, {31'd0, m_ovr});
        chk("err_udr", {31'd0, err_udr}, {31'd0, m_udr});
`endif
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rx_valid"}, {31'd0, rx_valid}, 32'd0);
        chk({tag, "_rx_data"},  {16'd0, rx_data},  32'd0);
        chk({tag, "_txe"},      {31'd0, txe},      32'd1);
        chk({tag, "_miso"},     {31'd0, miso},     32'd0);
        chk({tag, "_miso_oe"},  {31'd0, miso_oe},  32'd0);
        chk({tag, "_csn"},      {31'd0, csn_sync}, 32'd1);
    endtask

    // One word (or a leading part of one) from the master, mode 0
    task automatic send_word(input logic [15:0] w, input int nbits,
                             input int wr_at, input logic [15:0] wd);
        logic [15:0] mw = 16'h0;
        for (int i = 0; i < nbits; i++) begin
            mosi = w[15-i];
            #40;
            mw[15-i] = miso;
            if (i == 15) rx_q.push_back(w);
            sck = 1'b1;
            #40;
            sck = 1'b0;
            if (i == 1) chk("txe_in_word", {31'd0, txe}, {31'd0, ~m_full});
            if (i == wr_at) tx_write(wd);
        end
        if (nbits == 16) begin
            chk("miso_word", {16'd0, mw}, {16'd0, m_cur});
            m_cur = consume(1'b1);
        end
    endtask

    task automatic run_frame(input int nw, input int last_bits);
        @(posedge clk); #1;
        csn = 1'b0;
        #100;
        chk("frame_miso_oe", {31'd0, miso_oe}, 32'd1);
        m_cur = consume(1'b0);
        for (int k = 0; k < nw; k++) begin
            send_word(fw[k], (k == nw - 1) ? last_bits : 16, fwr_at[k], fwd[k]);
        end
        #100;
        csn = 1'b1;
        #100;
        chk("idle_miso_oe", {31'd0, miso_oe}, 32'd0);
        check_flags();
    endtask

    // RX monitor
    initial begin
        forever begin
            @(negedge clk);
            if (rx_valid === 1'b1) begin
                if (rx_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_unexpected actual=%0h required=no_pulse", rx_data);
                end else begin
                    chk("rx_data", {16'd0, rx_data}, {16'd0, rx_q.pop_front()});
                end
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        sck      = 1'b0;
        mosi     = 1'b0;
        csn      = 1'b1;
        tx_data  = 16'h0;
        tx_valid = 1'b0;
`ifdef SPI_PHY_ERR_FLAGS_EN
        err_clr  = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        check_flags();

        // Single word, empty TX buffer
        fw[0] = 16'h0101; fwr_at[0] = -1; fwd[0] = 16'h0;
        run_frame(1, 16);

        // Preloaded buffer, two-word burst, refill mid-word0
        tx_write(16'hA55A);
        #30;
        fw[0] = 16'h0205; fwr_at[0] = 6;  fwd[0] = 16'h4F4B;
        fw[1] = 16'h1234; fwr_at[1] = -1; fwd[1] = 16'h0;
        run_frame(2, 16);

        // Aborted word, then a clean one
        fw[0] = 16'hFFFF; fwr_at[0] = -1;
        run_frame(1, 9);
        fw[0] = 16'h00FF;
        run_frame(1, 16);

        // Overwrite of a held word; contents survive until the next frame
        tx_write(16'h1111);
        tx_write(16'h2222);
        #30;
        check_flags();
`ifdef SPI_PHY_ERR_FLAGS_EN
        @(posedge clk); #1 err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;
        m_ovr = 1'b0;
        m_udr = 1'b0;
        check_flags();
`endif
        fw[0] = 16'h5AC3; fwr_at[0] = -1;
        run_frame(1, 16);

        // Reset in the middle of a word flushes everything
        @(posedge clk); #1;
        csn = 1'b0;
        #100;
        m_cur = consume(1'b0);
        send_word(16'hFFFF, 3, 1, 16'h7777);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("midreset");
        rst_n  = 1'b1;
        m_full = 1'b0;
        m_ovr  = 1'b0;
        m_udr  = 1'b0;
        csn    = 1'b1;
        #150;
        fw[0] = 16'hBEEF; fwr_at[0] = -1;
        run_frame(1, 16);

        // Randomised frames
        for (int f = 0; f < 10; f++) begin
            int nw;
            int lb;
            nw = $urandom_range(1, 3);
            lb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : 16;
            for (int k = 0; k < nw; k++) begin
                fw[k]     = 16'($urandom);
                fwr_at[k] = ($urandom_range(0, 1) == 1) ? $urandom_range(2, 12) : -1;
                fwd[k]    = 16'($urandom);
            end
            if ($urandom_range(0, 1) == 1) begin
                tx_write(16'($urandom));
                #30;
            end
            run_frame(nw, lb);
        end

        #300;
        chk("rx_queue_drained", rx_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_spi_slave_phy
`default_nettype wire
